// File: rtl/enigma_session_ctrl_if.sv
// enigma_session_ctrl_if: UART byte and cipher-core handshake bundle for the session sequencer
interface enigma_session_ctrl_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       core_req;
    logic [4:0] core_char;
    logic       core_ack;
    logic [4:0] core_result;
    logic       banner_done;
    logic       overrun;
    modport master (
        input  rx_data, rx_valid, tx_busy, core_ack, core_result,
        output tx_data, tx_start, core_req, core_char, banner_done, overrun
    );
    modport slave (
        output rx_data, rx_valid, tx_busy, core_ack, core_result,
        input  tx_data, tx_start, core_req, core_char, banner_done, overrun
    );
endinterface

// File: rtl/enigma_session_ctrl.sv
// enigma_session_ctrl: startup banner, rx letter filtering, cipher core dispatch and tx of results
module enigma_session_ctrl #(
    parameter int STARTUP_CYCLES = 1200,
    parameter int BANNER_LEN     = 16
) (
    input logic                  clk,
    input logic                  rst,
    enigma_session_ctrl_if.master bus
);
    localparam int CW = $clog2(STARTUP_CYCLES + 1);
    localparam int IW = $clog2(BANNER_LEN);
    localparam logic [CW-1:0] LAST_CNT = CW'(STARTUP_CYCLES - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(BANNER_LEN - 1);
    localparam logic [7:0] ROM [16] = '{
        8'h45, 8'h4E, 8'h49, 8'h47, 8'h4D, 8'h41, 8'h20, 8'h49,
        8'h20, 8'h52, 8'h45, 8'h41, 8'h44, 8'h59, 8'h0D, 8'h0A
    };
    typedef enum logic [3:0] {
        STARTUP, B_SEND, B_GAP, B_WAIT, IDLE, C_REQ, T_SEND, T_GAP, T_WAIT
    } state_t;
    state_t        state;
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic          hold_full;
    logic [7:0]    hold_byte;
    logic          consume;
    logic          is_upper;
    logic          is_lower;
    assign consume  = (state == IDLE) && hold_full;
    assign is_upper = (hold_byte >= 8'h41) && (hold_byte <= 8'h5A);
    assign is_lower = (hold_byte >= 8'h61) && (hold_byte <= 8'h7A);
    // one-byte hold register; a byte arriving while it is full is lost and flagged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_full   <= 1'b0;
            hold_byte   <= 8'h00;
            bus.overrun <= 1'b0;
        end else if (bus.rx_valid) begin
            if (!hold_full || consume) begin
                hold_byte <= bus.rx_data;
                hold_full <= 1'b1;
            end else begin
                bus.overrun <= 1'b1;
            end
        end else if (consume) begin
            hold_full <= 1'b0;
        end
    end
    // session sequencer: startup wait, banner, then letter -> core -> tx loop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= STARTUP;
            cnt             <= '0;
            idx             <= '0;
            bus.tx_data     <= 8'h00;
            bus.tx_start    <= 1'b0;
            bus.core_req    <= 1'b0;
            bus.core_char   <= 5'd0;
            bus.banner_done <= 1'b0;
        end else begin
            bus.tx_start <= 1'b0;
            case (state)
                STARTUP: begin
                    if (cnt == LAST_CNT) state <= B_SEND;
                    else cnt <= cnt + 1'b1;
                end
                B_SEND: begin
                    if (!bus.tx_busy) begin
                        bus.tx_data  <= ROM[idx];
                        bus.tx_start <= 1'b1;
                        state        <= B_GAP;
                    end
                end
                B_GAP: state <= B_WAIT;
                B_WAIT: begin
                    if (!bus.tx_busy) begin
                        if (idx == LAST_IDX) begin
                            bus.banner_done <= 1'b1;
                            state           <= IDLE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= B_SEND;
                        end
                    end
                end
                IDLE: begin
                    if (hold_full && (is_upper || is_lower)) begin
                        bus.core_char <= is_upper ? 5'(hold_byte - 8'h41) : 5'(hold_byte - 8'h61);
                        bus.core_req  <= 1'b1;
                        state         <= C_REQ;
                    end
                end
                C_REQ: begin
                    if (bus.core_ack) begin
                        bus.core_req <= 1'b0;
                        bus.tx_data  <= {3'b000, bus.core_result} + 8'h41;
                        state        <= T_SEND;
                    end
                end
                T_SEND: begin
                    if (!bus.tx_busy) begin
                        bus.tx_start <= 1'b1;
                        state        <= T_GAP;
                    end
                end
                T_GAP: state <= T_WAIT;
                T_WAIT: begin
                    if (!bus.tx_busy) state <= IDLE;
                end
                default: state <= STARTUP;
            endcase
        end
    end
endmodule

// File: tb/tb_enigma_session_ctrl.sv
// tb_enigma_session_ctrl: scoreboard bench with UART tx and cipher core models
module tb_enigma_session_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    enigma_session_ctrl_if bus();
    enigma_session_ctrl #(.STARTUP_CYCLES(10), .BANNER_LEN(16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;

    int passed = 0;
    int total = 0;
    int cyc = 0;
    int t0 = 0;
    bit first_pending = 0;
    int tx_n = 0;
    int req_n = 0;
    int acks = 0;
    int rise_acks = 0;
    bit prev_req = 0;
    int bcnt = 0;
    int dly = 0;
    logic [7:0] exp_tx[$];
    logic [4:0] exp_core[$];
    logic [7:0] banner [16] = '{8'h45, 8'h4E, 8'h49, 8'h47, 8'h4D, 8'h41, 8'h20, 8'h49,
                                8'h20, 8'h52, 8'h45, 8'h41, 8'h44, 8'h59, 8'h0D, 8'h0A};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(posedge clk) cyc++;

    // TX model: busy for 10 cycles after each start
    always @(negedge clk) begin
        if (bus.tx_start) begin
            chk("tx_idle_at_start", bus.tx_busy, 0);
            bus.tx_busy = 1'b1;
            bcnt = 10;
        end else if (bcnt > 0) begin
            bcnt--;
            if (bcnt == 0) bus.tx_busy = 1'b0;
        end
    end

    // core model: acks after a short delay with (char+1) mod 26
    always @(negedge clk) begin
        if (bus.core_ack) begin
            bus.core_ack = 1'b0;
        end else if (bus.core_req) begin
            if (dly == 2) begin
                bus.core_result = 5'((int'(bus.core_char) + 1) % 26);
                bus.core_ack = 1'b1;
                acks++;
                dly = 0;
            end else dly++;
        end else dly = 0;
    end

    // monitor: pops expectations on tx_start and on core_req rising
    always @(negedge clk) begin
        if (rst) begin
            prev_req = 1'b0;
        end else begin
            if (bus.tx_start) begin
                tx_n++;
                if (first_pending) begin
                    chk("startup_delay", ((cyc - t0) >= 10 && (cyc - t0) <= 11), 1);
                    first_pending = 0;
                end
                if (exp_tx.size() == 0) chk("tx_unexpected", bus.tx_data, 8'hxx);
                else chk("tx_data", bus.tx_data, exp_tx.pop_front());
            end
            if (bus.core_req && !prev_req) begin
                req_n++;
                rise_acks = acks;
                if (exp_core.size() == 0) chk("core_unexpected", bus.core_char, 5'hxx);
                else chk("core_char", bus.core_char, exp_core.pop_front());
            end
            if (!bus.core_req && prev_req) chk("req_held_to_ack", acks > rise_acks, 1);
            prev_req = bus.core_req;
        end
    end

    task automatic send_rx(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic wait_quiet(input string name);
        int n = 0;
        while (n < 3000 && (exp_tx.size() != 0 || exp_core.size() != 0 || bus.tx_busy || bus.core_req)) begin
            @(negedge clk);
            n++;
        end
        chk(name, n < 3000, 1);
        repeat (5) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tx_data"}, bus.tx_data, 8'h00);
        chk({tag, "_tx_start"}, bus.tx_start, 1'b0);
        chk({tag, "_core_req"}, bus.core_req, 1'b0);
        chk({tag, "_core_char"}, bus.core_char, 5'd0);
        chk({tag, "_banner_done"}, bus.banner_done, 1'b0);
        chk({tag, "_overrun"}, bus.overrun, 1'b0);
    endtask

    task automatic release_with_banner();
        foreach (banner[i]) exp_tx.push_back(banner[i]);
        @(negedge clk);
        rst = 1'b0;
        t0 = cyc;
        first_pending = 1;
    endtask

    initial begin
        int tx0;
        int req0;
        bus.rx_data = 8'h00;
        bus.rx_valid = 1'b0;
        bus.tx_busy = 1'b0;
        bus.core_ack = 1'b0;
        bus.core_result = 5'd0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        release_with_banner();
        wait_quiet("banner_timeout");
        chk("banner_done", bus.banner_done, 1'b1);
        chk("banner_tx_count", tx_n, 16);

        exp_core.push_back(5'd0);
        exp_tx.push_back(8'h42);
        send_rx(8'h41);
        wait_quiet("upper_a_timeout");

        exp_core.push_back(5'd0);
        exp_core.push_back(5'd25);
        exp_tx.push_back(8'h42);
        exp_tx.push_back(8'h41);
        send_rx(8'h61);
        repeat (3) @(negedge clk);
        send_rx(8'h7A);
        wait_quiet("lower_timeout");
        chk("tx_data_after_z", bus.tx_data, 8'h41);

        tx0 = tx_n;
        req0 = req_n;
        send_rx(8'h35);
        repeat (3) @(negedge clk);
        send_rx(8'h20);
        repeat (3) @(negedge clk);
        send_rx(8'h0D);
        repeat (20) @(negedge clk);
        chk("nonletter_no_tx", tx_n, tx0);
        chk("nonletter_no_req", req_n, req0);
        chk("nonletter_no_overrun", bus.overrun, 1'b0);

        exp_core.push_back(5'd0);
        send_rx(8'h41);
        for (int n = 0; n < 50 && !bus.core_req; n++) @(negedge clk);
        chk("req_before_abort", bus.core_req, 1'b1);
        #2 rst = 1'b1;
        #1 check_reset_outputs("abort");
        repeat (3) @(negedge clk);
        release_with_banner();
        repeat (40) @(negedge clk);
        chk("in_banner", bus.banner_done, 1'b0);
        req0 = req_n;
        exp_core.push_back(5'd0);
        exp_tx.push_back(8'h42);
        send_rx(8'h41);
        send_rx(8'h42);
        wait_quiet("restart_timeout");
        chk("overrun_set", bus.overrun, 1'b1);
        chk("banner_done_again", bus.banner_done, 1'b1);
        chk("one_req_after_overrun", req_n - req0, 1);
        chk("queues_drained", exp_tx.size() + exp_core.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
